// File: rtl/vga_frame_reader.sv
// Frame fetcher feeding the VGA timing stage: pulls fixed-length SDRAM bursts
// into a local FIFO and hands out one RGB565 pixel per pix_req.
module vga_frame_reader #(
    parameter int H_ADDR    = 800,
    parameter int V_ADDR    = 600,
    parameter int BURST_LEN = 8,
    parameter int FIFO_AW   = 8,
    parameter int ADDR_W    = 22,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              sclk,
    input  logic              s_rst,
    input  logic              frame_start,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_data_vld,
    input  logic [15:0]       rd_data,
    input  logic              pix_req,
    output logic [15:0]       pix_data,
    output logic              underflow,
    output logic [FIFO_AW:0]  fifo_level
);
    localparam int FRAME_WORDS = H_ADDR * V_ADDR;
    localparam int WCNT_W      = $clog2(FRAME_WORDS + 1);
    localparam int BCNT_W      = $clog2(BURST_LEN + 1);
    localparam int DEPTH       = 1 << FIFO_AW;
    localparam logic [WCNT_W-1:0]  FRAME_CNT = WCNT_W'(FRAME_WORDS);
    localparam logic [FIFO_AW:0]   LEVEL_MAX = (FIFO_AW+1)'(DEPTH - BURST_LEN);
    localparam logic [BCNT_W-1:0]  LAST_BEAT = BCNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {IDLE, CHECK, REQ, DATA, DRAIN} state_t;

    state_t              state, state_next;
    logic [WCNT_W-1:0]   wcnt;
    logic [BCNT_W-1:0]   bcnt;
    logic                restart_pend;
    logic [15:0]         mem [DEPTH];
    logic [FIFO_AW-1:0]  wptr, rptr;
    logic                push, pop, fifo_empty, space_ok, last_beat, beat_phase;
    logic                do_reload, do_advance, bcnt_clr, pend_set, pend_clr;

    assign rd_req     = (state == REQ);
    assign fifo_empty = (fifo_level == '0);
    assign space_ok   = (fifo_level <= LEVEL_MAX);
    assign beat_phase = (state == DATA) || (state == DRAIN);
    assign last_beat  = rd_data_vld && (bcnt == LAST_BEAT);
    assign push       = rd_data_vld && (state == DATA) && !frame_start;
    assign pop        = pix_req && !fifo_empty && !frame_start;

    always_comb begin
        state_next = state;
        do_reload  = 1'b0;
        do_advance = 1'b0;
        bcnt_clr   = 1'b0;
        pend_set   = 1'b0;
        pend_clr   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_next = CHECK;
                    do_reload  = 1'b1;
                end
            end
            CHECK: begin
                if (frame_start)
                    do_reload = 1'b1;
                else if ((wcnt < FRAME_CNT) && space_ok)
                    state_next = REQ;
            end
            // The address must stay put until the ack, so a restart seen here
            // is remembered and the burst is drained afterwards.
            REQ: begin
                if (rd_ack) begin
                    bcnt_clr   = 1'b1;
                    pend_clr   = 1'b1;
                    state_next = (frame_start || restart_pend) ? DRAIN : DATA;
                end else if (frame_start) begin
                    pend_set = 1'b1;
                end
            end
            DATA: begin
                if (last_beat) begin
                    state_next = CHECK;
                    if (frame_start)
                        do_reload = 1'b1;
                    else
                        do_advance = 1'b1;
                end else if (frame_start) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (last_beat) begin
                    state_next = CHECK;
                    do_reload  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            state        <= IDLE;
            rd_addr      <= BASE_ADDR;
            wcnt         <= '0;
            bcnt         <= '0;
            restart_pend <= 1'b0;
        end else begin
            state <= state_next;
            if (do_reload) begin
                rd_addr <= BASE_ADDR;
                wcnt    <= '0;
            end else if (do_advance) begin
                rd_addr <= rd_addr + ADDR_W'(BURST_LEN);
                wcnt    <= wcnt + WCNT_W'(BURST_LEN);
            end
            if (bcnt_clr)
                bcnt <= '0;
            else if (beat_phase && rd_data_vld)
                bcnt <= last_beat ? '0 : bcnt + BCNT_W'(1);
            if (pend_clr)
                restart_pend <= 1'b0;
            else if (pend_set)
                restart_pend <= 1'b1;
        end
    end

    // FIFO control and the registered pixel output; flush overrides everything.
    always_ff @(posedge sclk or posedge s_rst) begin
        if (s_rst) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            underflow  <= 1'b0;
            pix_data   <= 16'h0000;
        end else if (frame_start) begin
            wptr       <= '0;
            rptr       <= '0;
            fifo_level <= '0;
            underflow  <= 1'b0;
            if (pix_req)
                pix_data <= 16'h0000;
        end else begin
            if (push)
                wptr <= wptr + FIFO_AW'(1);
            if (pop)
                rptr <= rptr + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (FIFO_AW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (FIFO_AW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (pix_req) begin
                pix_data <= pop ? mem[rptr] : 16'h0000;
                if (!pop)
                    underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge sclk) begin
        if (push)
            mem[wptr] <= rd_data;
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Bench for vga_frame_reader: SDRAM responder, FIFO/pixel scoreboard and
// directed sequences on a reduced 40x10 frame.
module tb_vga_frame_reader;
    localparam int H     = 40;
    localparam int V     = 10;
    localparam int BURST = 8;
    localparam int AW    = 8;
    localparam int FRAME = H * V;

    logic        sclk, s_rst, frame_start, rd_req, rd_ack, rd_data_vld, pix_req, underflow;
    logic [21:0] rd_addr;
    logic [15:0] rd_data, pix_data;
    logic [AW:0] fifo_level;

    vga_frame_reader #(
        .H_ADDR(H), .V_ADDR(V), .BURST_LEN(BURST), .FIFO_AW(AW), .ADDR_W(22), .BASE_ADDR(22'd0)
    ) dut (
        .sclk(sclk), .s_rst(s_rst), .frame_start(frame_start),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_data_vld(rd_data_vld), .rd_data(rd_data),
        .pix_req(pix_req), .pix_data(pix_data),
        .underflow(underflow), .fifo_level(fifo_level)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int checks = 0;
    int errors = 0;

    logic [15:0] mdl_q[$];
    logic [15:0] sb[$];
    logic [15:0] mdl_pix;
    logic        mdl_uf;
    int          exp_addr, phase, beat_n, dly_cnt, req_cnt, last_req_addr, pop_cnt;
    int          ack_dly;
    bit          ctrl_en, discard;
    logic [21:0] req_addr;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_clear();
        mdl_q.delete();
        sb.delete();
        mdl_pix  = 16'h0;
        mdl_uf   = 1'b0;
        exp_addr = 0;
        phase    = 0;
        beat_n   = 0;
        discard  = 1'b0;
        req_cnt  = 0;
        pop_cnt  = 0;
    endtask

    task automatic do_reset();
        s_rst = 1'b1;
        frame_start = 1'b0; pix_req = 1'b0;
        rd_ack = 1'b0; rd_data_vld = 1'b0; rd_data = 16'h0;
        repeat (3) @(posedge sclk);
        #1 s_rst = 1'b0;
        model_clear();
    endtask

    // One clock: check outputs produced by the previous cycle's inputs, run the
    // SDRAM responder, drive this cycle's inputs and update the reference model.
    task automatic cycle(input logic fs, input logic pr);
        bit          beat, burst_end;
        logic [15:0] bdata;
        beat = 1'b0; burst_end = 1'b0; bdata = 16'h0;
        @(posedge sclk); #1;
        if (sb.size() > 0) mdl_pix = sb.pop_front();
        chk("pix_data", int'(pix_data), int'(mdl_pix));
        chk("fifo_level", int'(fifo_level), mdl_q.size());
        chk("underflow", int'(underflow), int'(mdl_uf));
        rd_ack = 1'b0; rd_data_vld = 1'b0;
        if (ctrl_en) begin
            case (phase)
                0: if (rd_req) begin
                    chk("rd_addr", int'(rd_addr), exp_addr);
                    chk("req_within_frame", int'(exp_addr < FRAME), 1);
                    req_addr = rd_addr; last_req_addr = int'(rd_addr); req_cnt++;
                    if (ack_dly == 0) begin rd_ack = 1'b1; phase = 2; beat_n = 0; end
                    else begin dly_cnt = ack_dly; phase = 1; end
                end
                1: begin
                    chk("req_held", int'(rd_req), 1);
                    chk("addr_stable", int'(rd_addr), int'(req_addr));
                    dly_cnt--;
                    if (dly_cnt == 0) begin rd_ack = 1'b1; phase = 2; beat_n = 0; end
                end
                default: begin
                    chk("req_low_in_burst", int'(rd_req), 0);
                    rd_data_vld = 1'b1;
                    rd_data = req_addr[15:0] + 16'(beat_n) + 16'd1;
                    bdata = rd_data; beat = 1'b1; beat_n++;
                    if (beat_n == BURST) begin phase = 0; burst_end = 1'b1; end
                end
            endcase
        end
        frame_start = fs; pix_req = pr;
        if (fs) begin
            mdl_q.delete(); mdl_uf = 1'b0; exp_addr = 0;
            if (pr) sb.push_back(16'h0);
            discard = (phase != 0);
        end else begin
            if (pr) begin
                if (mdl_q.size() > 0) begin sb.push_back(mdl_q.pop_front()); pop_cnt++; end
                else begin sb.push_back(16'h0); mdl_uf = 1'b1; end
            end
            if (beat && !discard) mdl_q.push_back(bdata);
            if (burst_end) begin
                if (!discard) exp_addr += BURST;
                discard = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    typedef struct {
        logic fs;
        logic pr;
        int   exp_pix;
        int   exp_uf;
        int   exp_lvl;
    } vec_t;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        int   n;
        vt[0] = '{1'b0, 1'b1, 0, 1, 0};
        vt[1] = '{1'b1, 1'b0, 0, 0, 0};
        vt[2] = '{1'b0, 1'b1, 0, 1, 0};
        vt[3] = '{1'b0, 1'b0, 0, 1, 0};
        vt[4] = '{1'b1, 1'b1, 0, 0, 0};

        ctrl_en = 1'b0; ack_dly = 3; last_req_addr = -1;
        do_reset();
        chk("rst_rd_req", int'(rd_req), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_pix_data", int'(pix_data), 0);
        chk("rst_underflow", int'(underflow), 0);
        chk("rst_fifo_level", int'(fifo_level), 0);

        // Underflow / flush vectors with the SDRAM side silent
        for (int i = 0; i < 5; i++) begin
            cycle(vt[i].fs, vt[i].pr);
            cycle(1'b0, 1'b0);
            chk($sformatf("vec%0d_pix", i), int'(pix_data), vt[i].exp_pix);
            chk($sformatf("vec%0d_uf", i), int'(underflow), vt[i].exp_uf);
            chk($sformatf("vec%0d_lvl", i), int'(fifo_level), vt[i].exp_lvl);
        end

        // First burst with a slow ack, then fill the FIFO with a fast controller
        do_reset();
        ctrl_en = 1'b1; ack_dly = 3;
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        chk("req_not_yet", int'(rd_req), 0);
        cycle(1'b0, 1'b0);
        chk("req_two_after_fs", int'(rd_req), 1);
        n = 0;
        while (req_cnt < 2 && n < 100) begin cycle(1'b0, 1'b0); n++; end
        chk("second_req_seen", int'(req_cnt == 2), 1);
        chk("level_after_burst", int'(fifo_level), 8);
        chk("second_req_addr", last_req_addr, 8);

        ack_dly = 0;
        n = 0;
        while (fifo_level != 9'd256 && n < 1000) begin cycle(1'b0, 1'b0); n++; end
        idle(20);
        chk("full_level", int'(fifo_level), 256);
        chk("full_req_cnt", req_cnt, 32);
        cycle(1'b0, 1'b1);
        idle(20);
        chk("no_req_one_pop", req_cnt, 32);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1);
        idle(5);
        chk("req_after_8_pops", req_cnt, 33);

        // Restart after beat 3 of the second burst
        do_reset();
        ctrl_en = 1'b1; ack_dly = 1;
        cycle(1'b1, 1'b0);
        n = 0;
        while (!(req_cnt == 2 && phase == 2 && beat_n == 3) && n < 100) begin cycle(1'b0, 1'b0); n++; end
        chk("reached_beat3", int'(req_cnt == 2 && phase == 2 && beat_n == 3), 1);
        cycle(1'b1, 1'b0);
        n = 0;
        while (req_cnt < 3 && n < 100) begin cycle(1'b0, 1'b0); n++; end
        chk("restart_req_seen", int'(req_cnt == 3), 1);
        chk("restart_addr", int'(rd_addr), 0);
        chk("restart_level", int'(fifo_level), 0);
        idle(12);

        // Full frame at one pixel per cycle during the active part of each line
        do_reset();
        ctrl_en = 1'b1; ack_dly = 0;
        cycle(1'b1, 1'b0);
        idle(300);
        for (int l = 0; l < V; l++) begin
            for (int p = 0; p < H; p++) cycle(1'b0, 1'b1);
            idle(12);
        end
        idle(30);
        chk("frame_pixels", pop_cnt, FRAME);
        chk("frame_last_addr", last_req_addr, FRAME - BURST);
        chk("frame_req_cnt", req_cnt, FRAME / BURST);
        chk("frame_underflow", int'(underflow), 0);
        chk("frame_rd_req_idle", int'(rd_req), 0);

        // Asynchronous reset while a request is pending
        do_reset();
        ctrl_en = 1'b1; ack_dly = 3;
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b1);
        n = 0;
        while (req_cnt < 2 && n < 100) begin cycle(1'b0, 1'b0); n++; end
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        chk("pre_rst_rd_req", int'(rd_req), 1);
        chk("pre_rst_pix", int'(pix_data), 1);
        chk("pre_rst_uf", int'(underflow), 1);
        #2 s_rst = 1'b1;
        #1;
        chk("arst_rd_req", int'(rd_req), 0);
        chk("arst_rd_addr", int'(rd_addr), 0);
        chk("arst_pix_data", int'(pix_data), 0);
        chk("arst_underflow", int'(underflow), 0);
        chk("arst_fifo_level", int'(fifo_level), 0);
        do_reset();
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
